// File: rtl/fifo_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fifo_pkg : pointer helpers shared by the async FIFO controllers    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package fifo_pkg;

    localparam int FIFO_ADDR_WIDTH = 4;
    localparam int PTR_WIDTH       = FIFO_ADDR_WIDTH + 1;
    localparam int CODE_WIDTH      = 32;

    function automatic logic [CODE_WIDTH-1:0] bin2gray(input logic [CODE_WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Callers zero-extend, so the unused upper bits collapse to zero.
    function automatic logic [CODE_WIDTH-1:0] gray2bin(input logic [CODE_WIDTH-1:0] g);
        logic [CODE_WIDTH-1:0] b;
        b[CODE_WIDTH-1] = g[CODE_WIDTH-1];
        for (int i = CODE_WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gray_ptr_sync.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | gray_ptr_sync : STAGES-deep flop chain for a Gray pointer crossing |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module gray_ptr_sync #(
    parameter int WIDTH  = 5,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] chain [STAGES];

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        if (s == 0) begin : g_first
            always_ff @(posedge clk) begin
                if (!rst_n) chain[s] <= '0;
                else        chain[s] <= d;
            end
        end else begin : g_next
            always_ff @(posedge clk) begin
                if (!rst_n) chain[s] <= '0;
                else        chain[s] <= chain[s-1];
            end
        end
    end

    assign q = chain[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/rd_ctrl_sync.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rd_ctrl_sync : async FIFO read-side controller (pointer, flags,    |
// |                RAM read port). RD_CTRL_FWFT_EN selects FWFT mode.  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module rd_ctrl_sync
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH  = FIFO_ADDR_WIDTH,
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2,
    parameter int AE_THRESH   = 2
) (
    input  logic                  rd_clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH:0]   wr_ptr_gray,
    input  logic                  rd_en,
    output logic                  ram_ren,
    output logic [ADDR_WIDTH-1:0] ram_raddr,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic [ADDR_WIDTH:0]   rd_ptr_gray,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   rd_level,
    output logic                  underflow
);

    localparam int            PW       = ADDR_WIDTH + 1;
    localparam logic [PW-1:0] AE_LEVEL = PW'(AE_THRESH);

    logic [PW-1:0] rbin;
    logic [PW-1:0] rbin_next;
    logic [PW-1:0] rgray_next;
    logic [PW-1:0] wq_gray;
    logic [PW-1:0] wq_bin;
    logic [PW-1:0] level_next;
    logic          ren;
    logic          underflow_next;

    gray_ptr_sync #(
        .WIDTH  (PW),
        .STAGES (SYNC_STAGES)
    ) u_wptr_sync (
        .clk   (rd_clk),
        .rst_n (rst_n),
        .d     (wr_ptr_gray),
        .q     (wq_gray)
    );

    assign rbin_next  = rbin + PW'(ren);
    assign rgray_next = PW'(bin2gray(CODE_WIDTH'(rbin_next)));
    assign wq_bin     = PW'(gray2bin(CODE_WIDTH'(wq_gray)));
    assign level_next = wq_bin - rbin_next;
    assign ram_ren    = ren;
    assign ram_raddr  = rbin[ADDR_WIDTH-1:0];

    // Flags are registered from next-state values so a read and a pointer
    // arrival in the same cycle are both reflected on the following edge.
    always_ff @(posedge rd_clk) begin
        if (!rst_n) begin
            rbin         <= '0;
            rd_ptr_gray  <= '0;
            empty        <= 1'b1;
            almost_empty <= 1'b1;
            rd_level     <= '0;
            underflow    <= 1'b0;
        end else begin
            rbin         <= rbin_next;
            rd_ptr_gray  <= rgray_next;
            empty        <= (rgray_next == wq_gray);
            almost_empty <= (level_next <= AE_LEVEL);
            rd_level     <= level_next;
            underflow    <= underflow_next;
        end
    end

`ifdef RD_CTRL_FWFT_EN
    logic [DATA_WIDTH-1:0] out_data;
    logic [DATA_WIDTH-1:0] skid_data;
    logic                  out_valid;
    logic                  skid_valid;
    logic                  inflight;
    logic                  pop;
    logic [1:0]            occ_after_pop;

    // Buffer occupancy never exceeds 2, so two bits hold it.
    assign pop            = rd_en & out_valid;
    assign occ_after_pop  = 2'(out_valid) + 2'(skid_valid) + 2'(inflight) - 2'(pop);
    assign ren            = rst_n & ~empty & (occ_after_pop < 2'd2);
    assign underflow_next = rd_en & ~out_valid;
    assign rd_data        = out_data;
    assign rd_valid       = out_valid;

    always_ff @(posedge rd_clk) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            inflight   <= 1'b0;
        end else begin
            inflight <= ren;
            if (pop) begin
                if (skid_valid) begin
                    out_data   <= skid_data;
                    skid_valid <= inflight;
                    if (inflight) skid_data <= ram_rdata;
                end else begin
                    out_valid <= inflight;
                    if (inflight) out_data <= ram_rdata;
                end
            end else if (inflight) begin
                if (!out_valid) begin
                    out_valid <= 1'b1;
                    out_data  <= ram_rdata;
                end else begin
                    skid_valid <= 1'b1;
                    skid_data  <= ram_rdata;
                end
            end
        end
    end
`else
    logic valid_q;

    assign ren            = rst_n & rd_en & ~empty;
    assign underflow_next = rd_en & empty;
    assign rd_data        = ram_rdata;
    assign rd_valid       = valid_q;

    always_ff @(posedge rd_clk) begin
        if (!rst_n) valid_q <= 1'b0;
        else        valid_q <= ren;
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_rd_ctrl_sync.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_rd_ctrl_sync : bench for rd_ctrl_sync (ADDR_WIDTH=4, 2 stages)  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_rd_ctrl_sync;

    localparam int AW   = 4;
    localparam int DW   = 8;
    localparam int SYNC = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          rd_en;
    logic [AW:0]   wr_ptr_gray;
    logic          ram_ren;
    logic [AW-1:0] ram_raddr;
    logic [DW-1:0] ram_rdata;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic [AW:0]   rd_ptr_gray;
    logic          empty;
    logic          almost_empty;
    logic [AW:0]   rd_level;
    logic          underflow;

    logic [DW-1:0] mem [16];
    logic [DW-1:0] dq[$];
    int            wr_cnt = 0;
    int            n_chk  = 0;
    int            n_fail = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (ram_ren) ram_rdata <= mem[ram_raddr];

    rd_ctrl_sync dut (
        .rd_clk       (clk),
        .rst_n        (rst_n),
        .wr_ptr_gray  (wr_ptr_gray),
        .rd_en        (rd_en),
        .ram_ren      (ram_ren),
        .ram_raddr    (ram_raddr),
        .ram_rdata    (ram_rdata),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .rd_ptr_gray  (rd_ptr_gray),
        .empty        (empty),
        .almost_empty (almost_empty),
        .rd_level     (rd_level),
        .underflow    (underflow)
    );

    function automatic logic [AW:0] gray5(input int v);
        logic [AW:0] b;
        b = v[AW:0];
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Write side is emulated here: new words land in RAM before the pointer moves.
    task automatic drive(input bit r, input bit re, input int wtarget, output logic ren_seen);
        logic [DW-1:0] w;
        @(negedge clk);
        if (!r) begin
            wr_cnt = 0;
            dq.delete();
        end else begin
            while (wr_cnt < wtarget) begin
                w = DW'($urandom);
                mem[4'(wr_cnt)] = w;
                dq.push_back(w);
                wr_cnt++;
            end
        end
        rst_n       = r;
        rd_en       = re;
        wr_ptr_gray = gray5(wr_cnt);
        #1;
        ren_seen = ram_ren;
        @(posedge clk);
        #1;
    endtask

`ifndef RD_CTRL_FWFT_EN
    typedef struct {
        bit rst;
        bit re;
        int wr;
        bit ren;
        bit emp;
        bit ae;
        int lvl;
        bit uf;
        bit vld;
    } vec_t;

    // Reference: counts of words written/read, with the write count seen
    // through a SYNC-edge delay line.
    int            rd_cnt  = 0;
    int            sync_q [SYNC];
    bit            m_empty = 1'b1;
    bit            m_ae    = 1'b1;
    bit            m_uf    = 1'b0;
    bit            m_valid = 1'b0;
    int            m_level = 0;
    logic [DW-1:0] m_data;

    task automatic cycle(input bit r, input bit re, input int wtarget, output logic ren_seen);
        bit acc;
        int wq;
        acc = r && re && !m_empty;
        drive(r, re, wtarget, ren_seen);
        chk("ram_ren", ren_seen, acc);
        if (!r) begin
            rd_cnt = 0;
            foreach (sync_q[i]) sync_q[i] = 0;
            m_empty = 1'b1; m_ae = 1'b1; m_uf = 1'b0; m_valid = 1'b0; m_level = 0;
        end else begin
            wq      = sync_q[SYNC-1];
            m_uf    = re && m_empty;
            m_valid = acc;
            if (acc) begin
                rd_cnt++;
                m_data = dq.pop_front();
            end
            m_level = (wq - rd_cnt) & 31;
            m_empty = (m_level == 0);
            m_ae    = (m_level <= 2);
            for (int i = SYNC - 1; i > 0; i--) sync_q[i] = sync_q[i-1];
            sync_q[0] = wr_cnt & 31;
        end
        chk("empty", empty, m_empty);
        chk("almost_empty", almost_empty, m_ae);
        chk("rd_level", rd_level, m_level);
        chk("underflow", underflow, m_uf);
        chk("rd_valid", rd_valid, m_valid);
        chk("rd_ptr_gray", rd_ptr_gray, gray5(rd_cnt));
        if (m_valid) chk("rd_data", rd_data, m_data);
    endtask

    initial begin
        vec_t        tbl [11];
        logic        ren_seen;
        logic [AW:0] prev_g;
        int          wt;

        foreach (sync_q[i]) sync_q[i] = 0;
        rst_n = 1'b0; rd_en = 1'b0; wr_ptr_gray = '0;

        //            rst   re    wr  ren   emp   ae    lvl uf    vld
        tbl[0]  = '{1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 0, 1'b0, 1'b1, 1'b1, 0, 1'b1, 1'b0};
        tbl[2]  = '{1'b1, 1'b1, 0, 1'b0, 1'b1, 1'b1, 0, 1'b1, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, 0, 1'b0, 1'b1, 1'b1, 0, 1'b1, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 5, 1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 5, 1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 5, 1'b0, 1'b0, 1'b0, 5, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, 5, 1'b1, 1'b0, 1'b0, 4, 1'b0, 1'b1};
        tbl[8]  = '{1'b1, 1'b1, 5, 1'b1, 1'b0, 1'b0, 3, 1'b0, 1'b1};
        tbl[9]  = '{1'b1, 1'b1, 5, 1'b1, 1'b0, 1'b1, 2, 1'b0, 1'b1};
        tbl[10] = '{1'b1, 1'b0, 5, 1'b0, 1'b0, 1'b1, 2, 1'b0, 1'b0};

        for (int i = 0; i < 11; i++) begin
            cycle(tbl[i].rst, tbl[i].re, tbl[i].wr, ren_seen);
            chk($sformatf("tbl%0d_ren", i), ren_seen, tbl[i].ren);
            chk($sformatf("tbl%0d_empty", i), empty, tbl[i].emp);
            chk($sformatf("tbl%0d_ae", i), almost_empty, tbl[i].ae);
            chk($sformatf("tbl%0d_level", i), rd_level, tbl[i].lvl);
            chk($sformatf("tbl%0d_uf", i), underflow, tbl[i].uf);
            chk($sformatf("tbl%0d_valid", i), rd_valid, tbl[i].vld);
        end

        // Long random run: enough traffic to wrap both pointers several times.
        prev_g = rd_ptr_gray;
        for (int i = 0; i < 600; i++) begin
            wt = wr_cnt;
            if ($urandom_range(0, 2) != 0 && (wr_cnt - rd_cnt) < 16) wt = wr_cnt + 1;
            cycle(1'b1, ($urandom_range(0, 3) != 0), wt, ren_seen);
            chk("gray_one_bit_step", ($countones(rd_ptr_gray ^ prev_g) <= 1), 1);
            prev_g = rd_ptr_gray;
        end

        // Reset dropped into a back-to-back read burst.
        for (int i = 0; i < 12; i++) begin
            wt = ((wr_cnt - rd_cnt) < 16) ? wr_cnt + 1 : wr_cnt;
            cycle(1'b1, 1'b1, wt, ren_seen);
        end
        cycle(1'b0, 1'b1, 0, ren_seen);
        chk("rst_ren", ren_seen, 0);
        chk("rst_valid", rd_valid, 0);
        chk("rst_empty", empty, 1);
        chk("rst_level", rd_level, 0);
        chk("rst_gray", rd_ptr_gray, 0);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 1'b0, 0, ren_seen);
            chk("rst_no_ghost", rd_valid, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
`else
    initial begin
        logic          ren_seen;
        logic [DW-1:0] words [4];

        rst_n = 1'b0; rd_en = 1'b0; wr_ptr_gray = '0;
        drive(1'b0, 1'b0, 0, ren_seen);
        chk("fw_rst_valid", rd_valid, 0);
        chk("fw_rst_empty", empty, 1);

        for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, 4, ren_seen);
        for (int k = 0; k < 4; k++) words[k] = dq[k];
        chk("fw_hold_ren", ren_seen, 0);
        chk("fw_hold_valid", rd_valid, 1);
        chk("fw_hold_data", rd_data, words[0]);
        chk("fw_hold_level", rd_level, 2);
        chk("fw_hold_empty", empty, 0);
        chk("fw_hold_uf", underflow, 0);

        for (int k = 0; k < 4; k++) begin
            chk($sformatf("fw_word%0d_valid", k), rd_valid, 1);
            chk($sformatf("fw_word%0d_data", k), rd_data, words[k]);
            drive(1'b1, 1'b1, 4, ren_seen);
        end
        chk("fw_drain_valid", rd_valid, 0);
        chk("fw_drain_empty", empty, 1);
        chk("fw_drain_level", rd_level, 0);
        drive(1'b1, 1'b1, 4, ren_seen);
        chk("fw_underflow", underflow, 1);
        drive(1'b1, 1'b0, 4, ren_seen);
        chk("fw_underflow_clear", underflow, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
`endif

endmodule
`default_nettype wire

// File: doc/rd_ctrl_sync.md
Name: rd_ctrl_sync

Overview:
- Next-generation read-side controller for the asynchronous FIFO.
- Owns the read pointer and synchronises the write-domain Gray pointer into rd_clk.
- Generates registered empty, almost_empty and fill level, and drives the dual-port RAM read port.
- Sits between the shared RAM and the read-domain consumer; its Gray read pointer goes to the write-side controller.

Parameters:
- ADDR_WIDTH, 4, RAM address width; depth = 2**ADDR_WIDTH.
- DATA_WIDTH, 8, data word width.
- SYNC_STAGES, 2, flop stages in the write-pointer synchroniser (minimum 2).
- AE_THRESH, 2, almost_empty asserted when rd_level <= AE_THRESH.

Ports:
- rd_clk  in  1  read-domain clock
- rst_n  in  1  synchronous active-low reset
- wr_ptr_gray  in  ADDR_WIDTH+1  write pointer, Gray coded, write domain (asynchronous)
- rd_en  in  1  read request / pop
- ram_ren  out  1  RAM read enable
- ram_raddr  out  ADDR_WIDTH  RAM read address
- ram_rdata  in  DATA_WIDTH  RAM read data, valid 1 cycle after ram_ren
- rd_data  out  DATA_WIDTH  data to consumer
- rd_valid  out  1  rd_data valid
- rd_ptr_gray  out  ADDR_WIDTH+1  registered Gray read pointer to write domain
- empty  out  1  storage empty, registered
- almost_empty  out  1  registered
- rd_level  out  ADDR_WIDTH+1  words in RAM not yet read, registered
- underflow  out  1  one-cycle pulse on a rejected read

Behaviour:
- Reset (rst_n=0 at an rd_clk edge):
  - Binary and Gray pointers, synchroniser flops and rd_level go to 0; empty=1, almost_empty=1.
  - rd_valid=0, underflow=0, all in-flight reads discarded.
  - Reset asserted mid-transfer clears state on that edge; no RAM read issues in the reset cycle.
- Pointers:
  - rbin is ADDR_WIDTH+1 bits and wraps modulo 2**(ADDR_WIDTH+1); ram_raddr = rbin[ADDR_WIDTH-1:0].
  - rbin advances by 1 on every cycle ram_ren=1.
  - rd_ptr_gray = registered bin2gray(rbin_next), updated the same edge as rbin.
- Synchroniser: wr_ptr_gray passes through SYNC_STAGES flops to give wq_gray; wq_bin = gray2bin(wq_gray).
- Flags, registered from next-state values:
  - empty <= (bin2gray(rbin_next) == wq_gray).
  - rd_level <= wq_bin - rbin_next, modulo 2**(ADDR_WIDTH+1), range 0..2**ADDR_WIDTH.
  - almost_empty <= (rd_level_next <= AE_THRESH).
- Simultaneous read and write-pointer change: a read is accepted against the current registered empty; the next-state flags account for both events.
- underflow pulses for 1 cycle when the consumer requests a read while the block cannot service it (see mode rules). The pointer never moves on a rejected read.
- Standard mode (macro off):
  - ram_ren = rd_en & ~empty; underflow = registered (rd_en & empty).
  - rd_data = ram_rdata; rd_valid is ram_ren delayed 1 cycle.
  - Read latency: 1 cycle.

Optional Feature:
- RD_CTRL_FWFT_EN, defined: first-word-fall-through mode.
  - Output buffer is 2 deep: out register plus skid register.
  - occ = out_valid + skid_valid + inflight.
  - ram_ren = ~empty & (occ - pop < 2), where pop = rd_en & rd_valid.
  - Returning ram_rdata loads out if out is free or being popped, otherwise skid; skid moves to out on pop.
  - rd_data = out, rd_valid = out_valid; rd_en acts as acknowledge.
  - Sustains 1 word/cycle. Latency from empty falling to rd_valid rising is 2 cycles.
  - underflow = registered (rd_en & ~rd_valid).
  - rd_level excludes words held in the output buffer.
- RD_CTRL_FWFT_EN undefined: standard mode only, no output-buffer logic is synthesised.

Decomposition:
- Package fifo_pkg: bin2gray and gray2bin functions, plus a localparam for pointer width ADDR_WIDTH+1. The write-side controller shares this package.
- Sub-module gray_ptr_sync: parametrised SYNC_STAGES-deep flop chain with synchronous reset, reused on the write side.

Test Plan:
- Reset, then hold wr_ptr_gray=0 and rd_en=1 -> empty=1, almost_empty=1, rd_level=0, ram_ren=0, underflow pulses every cycle, rd_ptr_gray stays 0.
- Step wr_ptr_gray to gray(5) (ADDR_WIDTH=4, SYNC_STAGES=2) -> empty falls 3 cycles later; rd_level=5; almost_empty=0.
- Pop 3 words (rd_level goes 5->4->3->2) -> almost_empty rises on the edge rd_level reaches 2; data matches RAM addresses 0,1,2 with 1-cycle latency.
- Write 40 words at an unrelated clock ratio while reading continuously -> rbin wraps past 31 to 0 and ram_raddr past 15 to 0; all data arrives in order; rd_ptr_gray changes 1 bit per step; no underflow.
- Assert rst_n=0 for 1 cycle during a back-to-back read burst -> all outputs reach reset values next edge, and the in-flight word never appears on rd_valid.
- RD_CTRL_FWFT_EN defined, 4 words written, rd_en held low -> rd_valid=1 with word 0 and no pop, skid filled, rd_level=2. Then rd_en=1 for 4 cycles -> words 0..3 on consecutive cycles, then rd_valid=0 and empty=1.
